uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART serial transmitter, the transmit-side counterpart of the team's UART receiver.
- Serialises a parallel word onto `tx` as: start bit (0), `dbits` data bits LSB-first, an optional parity bit, then stop bit(s) (1).
- Bit timing comes from the shared oversampling `tick` (one pulse per 1/`sample` bit period), the same baud generator the receiver uses.

Parameters:
- dbits, 8, number of data bits per frame (5..9).
- sample, 16, tick pulses per bit period (>=2).
- stop_ticks, 16, tick pulses for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2 at sample=16).
- parity, 0, 0 = none, 1 = even, 2 = odd.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- tick  input  1  one-clk-wide enable pulse at `sample` x baud rate.
- tx_start  input  1  request to send `din`; honoured only when idle.
- din  input  dbits  word to transmit; sampled on the accepting edge.
- tx  output  1  serial line; idle high; driven from a register.
- busy  output  1  high from the cycle after acceptance until the return to idle.
- tx_done  output  1  one-clk pulse when the frame's stop period completes.

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE, tx=1, busy=0, tx_done=0, tick counter=0, bit counter=0, shift register=0. Reset is honoured in any state; a frame in progress is aborted and `tx` returns high on the next cycle.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_start=1: latch din into the shift register, compute the parity bit from din, clear the tick counter, go to START.
  - tx, busy and state change on the same edge, so `tx` is low the cycle after tx_start is sampled.
- Tick counting:
  - The tick counter increments only on cycles with tick=1 and clears on every state/bit transition.
  - A bit ends on the cycle where tick=1 and counter==sample-1 (STOP: counter==stop_ticks-1).
  - A bit therefore spans exactly `sample` tick pulses, whatever the spacing between ticks. Cycles without tick hold all state.
- START: tx=0 for `sample` ticks, then go to DATA with bit counter=0.
- DATA:
  - tx = shift register bit 0.
  - At each bit end, shift right by 1 and increment the bit counter.
  - After bit dbits-1 ends, go to PARITY if parity!=0, else STOP.
- PARITY: tx = p, where p = XOR of the data bits for even parity and its inverse for odd; lasts `sample` ticks, then STOP.
- STOP:
  - tx=1 for stop_ticks ticks.
  - At the end: tx_done=1 for that single cycle, next state IDLE, busy drops on the following edge.
- busy = (state != IDLE), registered.
- Requests are not queued:
  - tx_start while busy=1 is ignored.
  - tx_start asserted in the tx_done cycle is also ignored; the earliest accepted start is the cycle after tx_done.
  - Changing din while busy has no effect on the current frame.
- Frame length in ticks = sample*(1+dbits+(parity!=0)) + stop_ticks. Example: 160 ticks at the defaults.
- Arithmetic: the tick counter is wide enough for max(sample, stop_ticks)-1; the bit counter is clog2(dbits+1) bits. No wrap occurs within a legal frame.
- tick asserted during IDLE is ignored; the tick counter stays 0.

Test Plan:
- Defaults, tick every 4 clk, din=0xA5, one-cycle tx_start -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 ticks (64 clk); tx_done pulses once, 640 clk after acceptance; busy high throughout.
- Back-to-back: 0x00 then 0xFF, with tx_start held high continuously -> second start bit begins 1 clk after busy falls; no glitch high→low shorter than one stop period; exactly two tx_done pulses.
- tx_start pulsed and din changed to 0x3C mid-frame of 0x81 -> frame still carries 0x81; no second frame starts.
- parity=1 with din=0x07 -> parity bit 1; parity=2 with din=0x07 -> parity bit 0; frame is 176 ticks.
- rst=0 for 1 clk during DATA bit 3 -> next cycle tx=1, busy=0, tx_done=0, no tx_done afterwards; a new tx_start then sends a complete, correct frame.
- Irregular tick spacing (random gaps of 1..20 clk), din=0x5A -> each bit still spans exactly 16 tick pulses; a receiver model decodes 0x5A.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx : UART serial transmitter.
//
// Sends one frame per accepted request: a start bit (0), dbits data bits
// LSB-first, an optional parity bit, then the stop period (1). Bit timing is
// taken from the shared oversampling tick, the same enable the receiver uses.
// Each bit lasts `sample` tick pulses and the stop period lasts `stop_ticks`
// pulses, however far apart the pulses are.
//
// Parameters
//   dbits      data bits per frame (5..9)
//   sample     tick pulses per bit period (>= 2)
//   stop_ticks tick pulses in the stop period (16/24/32 = 1/1.5/2 stop bits)
//   parity     0 = none, 1 = even, 2 = odd
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   tick       one-clk enable pulse at sample x baud
//   tx_start   send request, honoured only when idle
//   din        word to send, captured on the accepting edge
//   tx         serial line, idle high, registered
//   busy       high while a frame is in progress, registered
//   tx_done    one-clk pulse in the cycle that ends the stop period
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int dbits      = 8,
    parameter int sample     = 16,
    parameter int stop_ticks = 16,
    parameter int parity     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             tx_start,
    input  logic [dbits-1:0] din,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int tick_max = (sample > stop_ticks) ? sample : stop_ticks;
    localparam int tw       = (tick_max > 1) ? $clog2(tick_max) : 1;
    localparam int bw       = $clog2(dbits + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state, state_next;
    logic [tw-1:0]      tick_cnt, tick_cnt_next;
    logic [bw-1:0]      bit_cnt, bit_cnt_next;
    logic [dbits-1:0]   shreg, shreg_next;
    logic               par_bit, par_next;
    logic               tx_next;
    logic               busy_next;

    // End of a regular bit and end of the stop period. Both only fire on a
    // tick cycle, so gaps between ticks never shorten or stretch a bit.
    logic bit_end, stop_end;
    assign bit_end  = tick && (tick_cnt == tw'(sample - 1));
    assign stop_end = tick && (tick_cnt == tw'(stop_ticks - 1));

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick ? tick_cnt + tw'(1) : tick_cnt;
        bit_cnt_next  = bit_cnt;
        shreg_next    = shreg;
        par_next      = par_bit;
        tx_next       = tx;
        tx_done       = 1'b0;

        case (state)
            IDLE: begin
                // Ticks are ignored while idle so the first bit always starts
                // from a clean count.
                tx_next       = 1'b1;
                tick_cnt_next = '0;
                if (tx_start) begin
                    shreg_next = din;
                    par_next   = (^din) ^ 1'(parity == 2);
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    tick_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = DATA;
                    tx_next       = shreg[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    tick_cnt_next = '0;
                    shreg_next    = shreg >> 1;
                    bit_cnt_next  = bit_cnt + bw'(1);
                    if (bit_cnt == bw'(dbits - 1)) begin
                        if (parity != 0) begin
                            state_next = PARITY;
                            tx_next    = par_bit;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        // The line register shows the bit that the shift
                        // brings into position 0.
                        tx_next = shreg[1];
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    tick_cnt_next = '0;
                    state_next    = STOP;
                    tx_next       = 1'b1;
                end
            end

            STOP: begin
                tx_next = 1'b1;
                if (stop_end) begin
                    // tx_done is seen while the frame still owns the line, so a
                    // request in this same cycle falls into the busy window.
                    tick_cnt_next = '0;
                    tx_done       = 1'b1;
                    state_next    = IDLE;
                end
            end

            default: begin
                state_next    = IDLE;
                tick_cnt_next = '0;
                tx_next       = 1'b1;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            bit_cnt  <= bit_cnt_next;
            shreg    <= shreg_next;
            par_bit  <= par_next;
            tx       <= tx_next;
            busy     <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx : directed self-checking bench for uart_tx.
//
// Three transmitters share clk, rst, tick and din: one with no parity, one
// with even parity and one with odd parity. Each has its own tx_start. Expected
// line levels come from a frame model built from the word being sent, and a
// mid-bit sampling receiver model decodes each frame.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [7:0] din;
    logic [2:0] start;
    logic [2:0] txv, bsy, dn;
    logic [2:0] done_seen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.dbits(8), .sample(16), .stop_ticks(16), .parity(0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start[0]), .din(din),
        .tx(txv[0]), .busy(bsy[0]), .tx_done(dn[0])
    );
    uart_tx #(.dbits(8), .sample(16), .stop_ticks(16), .parity(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start[1]), .din(din),
        .tx(txv[1]), .busy(bsy[1]), .tx_done(dn[1])
    );
    uart_tx #(.dbits(8), .sample(16), .stop_ticks(16), .parity(2)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start[2]), .din(din),
        .tx(txv[2]), .busy(bsy[2]), .tx_done(dn[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change at the falling edge, tx_done is sampled while
    // those inputs are stable, registered outputs are read 1 ns after the
    // rising edge.
    task automatic step(input logic t, input logic [2:0] s);
        @(negedge clk);
        tick  = t;
        start = s;
        #1;
        done_seen = dn;
        @(posedge clk);
        #1;
    endtask

    // Sends one frame on instance sel and follows it tick by tick.
    // mode 0: quiet request line; 1: tx_start held high throughout;
    // 2: extra request and din change mid-frame; 3: random tick gaps 1..20.
    task automatic run(input int sel, input logic [7:0] d, input int par, input int mode,
                       output logic [7:0] rx, output logic rx_par,
                       output int done_clk, output int ndone, output int bad);
        logic [10:0] exp_bits;
        int nb, total, ticks, clk_cnt, gap_left, idx;
        logic t, s, exp_tx, exp_busy;

        exp_bits = '0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
        nb = (par != 0) ? 10 : 9;
        if (par == 1) exp_bits[9] = ^d;
        if (par == 2) exp_bits[9] = ~(^d);
        total    = 16 * nb + 16;
        ticks    = 0;
        clk_cnt  = 0;
        done_clk = -1;
        ndone    = 0;
        bad      = 0;
        rx       = '0;
        rx_par   = 1'bx;

        // Acceptance cycle, with a tick that must be ignored in IDLE.
        din = d;
        step(1'b1, 3'(1 << sel));
        check("accept_tx", 32'(txv[sel]), 32'd0);
        check("accept_busy", 32'(bsy[sel]), 32'd1);

        gap_left = (mode == 3) ? $urandom_range(20, 1) : 4;
        while (ticks < total && clk_cnt < 20000) begin
            clk_cnt++;
            gap_left--;
            t = (gap_left == 0);
            if (t) gap_left = (mode == 3) ? $urandom_range(20, 1) : 4;
            s = (mode == 1);
            if (mode == 2 && clk_cnt == 100) begin
                s   = 1'b1;
                din = 8'h3C;
            end
            step(t, s ? 3'(1 << sel) : 3'b000);
            if (done_seen[sel]) begin
                ndone++;
                done_clk = clk_cnt;
            end
            if (t) ticks++;
            idx      = ticks / 16;
            exp_tx   = (idx >= nb) ? 1'b1 : exp_bits[idx];
            exp_busy = (ticks < total);
            if (txv[sel] !== exp_tx || bsy[sel] !== exp_busy) bad++;
            if (t && (ticks % 16) == 8) begin
                if (idx >= 1 && idx <= 8) rx[idx-1] = txv[sel];
                if (idx == 9 && par != 0) rx_par = txv[sel];
            end
        end
        check("frame_complete", 32'(ticks), 32'(total));
        tick  = 1'b0;
        start = 3'b000;
    endtask

    // Idle cycles with regular ticks; counts any activity on instance 0.
    task automatic idle_watch(input int n, output int activity);
        activity = 0;
        for (int i = 1; i <= n; i++) begin
            step((i % 4) == 0, 3'b000);
            if (done_seen[0] || !txv[0] || bsy[0]) activity++;
        end
    endtask

    logic [7:0] rx;
    logic       rx_par;
    int         done_clk, ndone, bad, activity, rticks;

    initial begin
        rst   = 1'b0;
        tick  = 1'b0;
        start = 3'b000;
        din   = 8'h00;

        // Reset, with a tick and a request present to show both are overridden.
        step(1'b1, 3'b111);
        step(1'b0, 3'b000);
        check("reset_tx", 32'(txv), 32'h7);
        check("reset_busy", 32'(bsy), 32'h0);
        check("reset_done", 32'(done_seen), 32'h0);
        rst = 1'b1;
        step(1'b0, 3'b000);

        // 0xA5, tick every 4 clk: line 0,1,0,1,0,0,1,0,1,1 at 16 ticks each.
        run(0, 8'hA5, 0, 0, rx, rx_par, done_clk, ndone, bad);
        check("a5_bits", 32'(bad), 32'd0);
        check("a5_decode", 32'(rx), 32'hA5);
        check("a5_done_cnt", 32'(ndone), 32'd1);
        check("a5_done_clk", 32'(done_clk), 32'd640);

        // Back-to-back 0x00 then 0xFF with tx_start held high.
        run(0, 8'h00, 0, 1, rx, rx_par, done_clk, ndone, bad);
        check("b2b0_bits", 32'(bad), 32'd0);
        check("b2b0_decode", 32'(rx), 32'h00);
        check("b2b0_done_cnt", 32'(ndone), 32'd1);
        run(0, 8'hFF, 0, 1, rx, rx_par, done_clk, ndone, bad);
        check("b2b1_bits", 32'(bad), 32'd0);
        check("b2b1_decode", 32'(rx), 32'hFF);
        check("b2b1_done_cnt", 32'(ndone), 32'd1);
        idle_watch(8, activity);
        check("b2b_end_idle", 32'(activity), 32'd0);

        // Mid-frame request and din change must not disturb 0x81.
        run(0, 8'h81, 0, 2, rx, rx_par, done_clk, ndone, bad);
        check("mid_bits", 32'(bad), 32'd0);
        check("mid_decode", 32'(rx), 32'h81);
        check("mid_done_cnt", 32'(ndone), 32'd1);
        idle_watch(100, activity);
        check("mid_no_second", 32'(activity), 32'd0);

        // Even and odd parity on 0x07 (three ones): 176-tick frames.
        run(1, 8'h07, 1, 0, rx, rx_par, done_clk, ndone, bad);
        check("even_bits", 32'(bad), 32'd0);
        check("even_decode", 32'(rx), 32'h07);
        check("even_parity", 32'(rx_par), 32'd1);
        check("even_done_clk", 32'(done_clk), 32'd704);
        run(2, 8'h07, 2, 0, rx, rx_par, done_clk, ndone, bad);
        check("odd_bits", 32'(bad), 32'd0);
        check("odd_parity", 32'(rx_par), 32'd0);
        check("odd_done_clk", 32'(done_clk), 32'd704);

        // Reset during data bit 3 of 0x96.
        din = 8'h96;
        step(1'b1, 3'b001);
        rticks = 0;
        for (int i = 1; i <= 2000 && rticks < 16 * 4 + 5; i++) begin
            step((i % 4) == 0, 3'b000);
            if ((i % 4) == 0) rticks++;
        end
        check("abort_in_frame", 32'(bsy[0]), 32'd1);
        rst = 1'b0;
        step(1'b1, 3'b000);
        rst = 1'b1;
        check("abort_tx", 32'(txv[0]), 32'd1);
        check("abort_busy", 32'(bsy[0]), 32'd0);
        step(1'b0, 3'b000);
        check("abort_done", 32'(done_seen[0]), 32'd0);
        idle_watch(700, activity);
        check("abort_quiet", 32'(activity), 32'd0);
        run(0, 8'h96, 0, 0, rx, rx_par, done_clk, ndone, bad);
        check("after_abort_bits", 32'(bad), 32'd0);
        check("after_abort_decode", 32'(rx), 32'h96);
        check("after_abort_done_clk", 32'(done_clk), 32'd640);

        // Irregular tick spacing.
        run(0, 8'h5A, 0, 3, rx, rx_par, done_clk, ndone, bad);
        check("jitter_bits", 32'(bad), 32'd0);
        check("jitter_decode", 32'(rx), 32'h5A);
        check("jitter_done_cnt", 32'(ndone), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
